// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: issues word addresses to a 1-cycle BRAM, buffers the
// returned words in a small FIFO and hands {pc, instr} to decode over valid/ready.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e                       state_q, state_d;
  logic [31:0]                  fetch_pc_q, fetch_pc_d;
  logic [31:0]                  inflight_pc_q, inflight_pc_d;
  logic [CW-1:0]                inflight_q, inflight_d;
  logic [CW-1:0]                count_q, count_d;
  logic                         kill_q, kill_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  entry_t [FIFO_DEPTH-1:0]      fifo_q, fifo_d;

  logic        pop, push, issue, drop_stale;
  logic [CW:0] credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // State register (FSM + datapath)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= '0;
      count_q       <= '0;
      kill_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      count_q       <= count_d;
      kill_q        <= kill_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_q        <= fifo_d;
    end
  end

  // Next-state: any redirect (from RUN or FLUSH) lands in FLUSH; latest target wins.
  always_comb begin
    state_d = RUN;
    if (redirect_valid) state_d = FLUSH;
  end

  // FSM outputs
  always_comb begin
    drop_stale = 1'b0;
    if (state_q == FLUSH) drop_stale = kill_q;
  end

  assign out_valid = (count_q != '0);
  assign out_pc    = fifo_q[rd_ptr_q].pc;
  assign out_instr = fifo_q[rd_ptr_q].instr;
  assign imem_addr = fetch_pc_q;

  assign pop  = out_valid && out_ready;
  // A word returning during a redirect cycle dies with the FIFO clear.
  assign push = (inflight_q != '0) && !drop_stale && !redirect_valid;

  // Credit: buffered + in-flight words never exceed the FIFO depth.
  assign credit_used = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue       = !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = '0;
    count_d       = count_q;
    kill_d        = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_d        = fifo_q;
    if (redirect_valid) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      kill_d     = (inflight_q != '0);
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      if (issue) begin
        inflight_d    = CW'(1);
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
      if (push) begin
        fifo_d[wr_ptr_q] = '{pc: inflight_pc_q, instr: imem_rdata};
        wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end
endmodule
